// File: rtl/bp_cce_dir_sharers_collect_if.sv
// Bus bundle for the directory sharers collector.
//   start_v_i / ready_o / set_i / tag_i : read request handshake
//   ram_v_o / ram_addr_o / ram_data_i   : directory RAM read port (1-cycle latency)
//   sharers_*                           : assembled per-LCE result vectors
// Modport master is the collector; modport slave is its environment.
`ifndef BP_COH_BITS
`define BP_COH_BITS 3
`endif

interface bp_cce_dir_sharers_collect_if #(
    parameter int num_lce_p     = 4,
    parameter int lce_assoc_p   = 2,
    parameter int lce_per_row_p = 2,
    parameter int dir_sets_p    = 8,
    parameter int tag_width_p   = 8
);
    localparam int coh_w_lp      = `BP_COH_BITS;
    localparam int rows_lp       = num_lce_p / lce_per_row_p;
    localparam int entry_w_lp    = tag_width_p + coh_w_lp;
    localparam int row_w_lp      = lce_per_row_p * lce_assoc_p * entry_w_lp;
    localparam int ram_addr_w_lp = (dir_sets_p * rows_lp > 1) ? $clog2(dir_sets_p * rows_lp) : 1;
    localparam int set_w_lp      = (dir_sets_p > 1) ? $clog2(dir_sets_p) : 1;
    localparam int way_w_lp      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;

    logic                            start_v_i;
    logic                            ready_o;
    logic [set_w_lp-1:0]             set_i;
    logic [tag_width_p-1:0]          tag_i;
    logic                            ram_v_o;
    logic [ram_addr_w_lp-1:0]        ram_addr_o;
    logic [row_w_lp-1:0]             ram_data_i;
    logic                            sharers_v_o;
    logic [num_lce_p-1:0]            sharers_hits_o;
    logic [num_lce_p*way_w_lp-1:0]   sharers_ways_o;
    logic [num_lce_p*coh_w_lp-1:0]   sharers_coh_states_o;

    modport master (
        input  start_v_i, set_i, tag_i, ram_data_i,
        output ready_o, ram_v_o, ram_addr_o,
               sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o
    );

    modport slave (
        output start_v_i, set_i, tag_i, ram_data_i,
        input  ready_o, ram_v_o, ram_addr_o,
               sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o
    );
endinterface

// File: rtl/bp_cce_dir_sharers_collect.sv
// Directory read-out collector. Streams the way-group rows of one directory
// set out of the RAM, compares every entry against the requested tag and
// assembles per-LCE hit / way / coherence-state vectors, signalled by a
// one-cycle sharers_v_o pulse.
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   bus        : request handshake, RAM read port and result vectors (master side)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; results held from the previous request
// READ  | one RAM row read issued per cycle, row counter 0..rows_lp-1
// DONE  | last row's data is compared; valid pulse follows in IDLE
`ifndef BP_COH_BITS
`define BP_COH_BITS 3
`endif

module bp_cce_dir_sharers_collect #(
    parameter int num_lce_p     = 4,
    parameter int lce_assoc_p   = 2,
    parameter int lce_per_row_p = 2,
    parameter int dir_sets_p    = 8,
    parameter int tag_width_p   = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bp_cce_dir_sharers_collect_if.master bus
);
    localparam int coh_w_lp      = `BP_COH_BITS;
    localparam int rows_lp       = num_lce_p / lce_per_row_p;
    localparam int entry_w_lp    = tag_width_p + coh_w_lp;
    localparam int ram_addr_w_lp = (dir_sets_p * rows_lp > 1) ? $clog2(dir_sets_p * rows_lp) : 1;
    localparam int set_w_lp      = (dir_sets_p > 1) ? $clog2(dir_sets_p) : 1;
    localparam int way_w_lp      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
    localparam int cnt_w_lp      = (rows_lp > 1) ? $clog2(rows_lp) : 1;

    typedef enum logic [1:0] {IDLE_S, READ_S, DONE_S} state_e;

    state_e                        state_q, state_d;
    logic [set_w_lp-1:0]           set_q;
    logic [tag_width_p-1:0]        tag_q;
    logic [cnt_w_lp-1:0]           row_cnt_q;
    logic                          cmp_v_q;
    logic [cnt_w_lp-1:0]           cmp_row_q;
    logic                          ram_v_q;
    logic                          sharers_v_q;
    logic [num_lce_p-1:0]          hits_q;
    logic [num_lce_p*way_w_lp-1:0] ways_q;
    logic [num_lce_p*coh_w_lp-1:0] states_q;

    logic                          accept;
    logic                          last_row;

    logic                          row_hit   [lce_per_row_p];
    logic [way_w_lp-1:0]           row_way   [lce_per_row_p];
    logic [coh_w_lp-1:0]           row_state [lce_per_row_p];

    assign accept   = (state_q == IDLE_S) && bus.start_v_i;
    assign last_row = (row_cnt_q == cnt_w_lp'(rows_lp - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE_S;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_S:  if (bus.start_v_i) state_d = READ_S;
            READ_S:  if (last_row)      state_d = DONE_S;
            DONE_S:                     state_d = IDLE_S;
            default:                    state_d = IDLE_S;
        endcase
    end

    // Decoded outputs
    always_comb begin
        bus.ready_o    = (state_q == IDLE_S);
        bus.ram_addr_o = '0;
        if (state_q == READ_S)
            bus.ram_addr_o = ram_addr_w_lp'(set_q) * ram_addr_w_lp'(rows_lp)
                           + ram_addr_w_lp'(row_cnt_q);
    end

    // Per-row compare. Ways are scanned high to low so the lowest hitting
    // way is the one that sticks.
    always_comb begin
        logic [entry_w_lp-1:0] entry;
        entry = '0;
        for (int l = 0; l < lce_per_row_p; l++) begin
            row_hit[l]   = 1'b0;
            row_way[l]   = '0;
            row_state[l] = '0;
            for (int w = lce_assoc_p - 1; w >= 0; w--) begin
                entry = bus.ram_data_i[(l*lce_assoc_p + w)*entry_w_lp +: entry_w_lp];
                if (entry[entry_w_lp-1:coh_w_lp] == tag_q && entry[coh_w_lp-1:0] != '0) begin
                    row_hit[l]   = 1'b1;
                    row_way[l]   = way_w_lp'(w);
                    row_state[l] = entry[coh_w_lp-1:0];
                end
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            set_q       <= '0;
            tag_q       <= '0;
            row_cnt_q   <= '0;
            cmp_v_q     <= 1'b0;
            cmp_row_q   <= '0;
            ram_v_q     <= 1'b0;
            sharers_v_q <= 1'b0;
            hits_q      <= '0;
            ways_q      <= '0;
            states_q    <= '0;
        end else begin
            ram_v_q     <= (state_d == READ_S);
            cmp_v_q     <= (state_q == READ_S);
            cmp_row_q   <= row_cnt_q;
            sharers_v_q <= (state_q == DONE_S);

            if (accept) begin
                set_q     <= bus.set_i;
                tag_q     <= bus.tag_i;
                row_cnt_q <= '0;
                hits_q    <= '0;
                ways_q    <= '0;
                states_q  <= '0;
            end else begin
                if (state_q == READ_S && !last_row)
                    row_cnt_q <= row_cnt_q + 1'b1;
                if (cmp_v_q) begin
                    for (int g = 0; g < num_lce_p; g++) begin
                        if (cnt_w_lp'(g / lce_per_row_p) == cmp_row_q) begin
                            hits_q[g]                        <= row_hit[g % lce_per_row_p];
                            ways_q[g*way_w_lp +: way_w_lp]   <= row_way[g % lce_per_row_p];
                            states_q[g*coh_w_lp +: coh_w_lp] <= row_state[g % lce_per_row_p];
                        end
                    end
                end
            end
        end
    end

    assign bus.ram_v_o              = ram_v_q;
    assign bus.sharers_v_o          = sharers_v_q;
    assign bus.sharers_hits_o       = hits_q;
    assign bus.sharers_ways_o       = ways_q;
    assign bus.sharers_coh_states_o = states_q;
endmodule

// File: tb/tb_bp_cce_dir_sharers_collect.sv
module tb_bp_cce_dir_sharers_collect;
    localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_M = 3'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_cce_dir_sharers_collect_if #(.num_lce_p(4), .lce_assoc_p(2), .lce_per_row_p(2),
                                    .dir_sets_p(8), .tag_width_p(8)) bus ();

    bp_cce_dir_sharers_collect #(.num_lce_p(4), .lce_assoc_p(2), .lce_per_row_p(2),
                                 .dir_sets_p(8), .tag_width_p(8))
        dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));

    // Directory RAM model, one-cycle read latency
    logic [43:0] mem [16];
    always @(posedge clk) if (bus.ram_v_o) bus.ram_data_i <= mem[bus.ram_addr_o];

    typedef struct { int cyc; logic [3:0] hits; logic [3:0] ways; logic [11:0] st; } exp_t;
    typedef struct { int cyc; int addr; } addr_t;
    exp_t  sb_q[$];
    addr_t ad_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] ent(logic [7:0] t, logic [2:0] s);
        return {t, s};
    endfunction

    // e0=l0w0, e1=l0w1, e2=l1w0, e3=l1w1
    function automatic logic [43:0] mk_row(logic [10:0] e0, logic [10:0] e1,
                                           logic [10:0] e2, logic [10:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Result monitor
    always @(negedge clk) begin
        if (bus.sharers_v_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_sharers_v", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("hits", bus.sharers_hits_o, e.hits);
                chk("ways", bus.sharers_ways_o, e.ways);
                chk("coh_states", bus.sharers_coh_states_o, e.st);
            end
        end
    end

    // RAM address monitor
    always @(negedge clk) begin
        if (bus.ram_v_o) begin
            if (ad_q.size() == 0) begin
                chk("unexpected_ram_read", 1, 0);
            end else begin
                addr_t a;
                a = ad_q.pop_front();
                chk("ram_cycle", cyc, a.cyc);
                chk("ram_addr", bus.ram_addr_o, a.addr);
            end
        end
    end

    // Issue a single request at the current negedge (cycle k)
    task automatic req(int set, logic [7:0] tag, logic [3:0] h, logic [3:0] w, logic [11:0] s);
        int k;
        k = cyc;
        chk("ready_before_start", bus.ready_o, 1);
        bus.start_v_i = 1'b1;
        bus.set_i     = 3'(set);
        bus.tag_i     = tag;
        ad_q.push_back('{k + 1, set * 2});
        ad_q.push_back('{k + 2, set * 2 + 1});
        sb_q.push_back('{k + 4, h, w, s});
        @(negedge clk);
        bus.start_v_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        bus.start_v_i = 1'b0;
        bus.set_i     = '0;
        bus.tag_i     = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        // set 3: all miss for tag 5A
        mem[6]  = mk_row(ent(8'h11, ST_M), ent(8'h11, ST_M), ent(8'h11, ST_M), ent(8'h11, ST_M));
        mem[7]  = mk_row(ent(8'h11, ST_M), ent(8'h11, ST_M), ent(8'h11, ST_M), ent(8'h11, ST_M));
        // set 5: mixed hits
        mem[10] = mk_row(ent(8'h11, ST_M), ent(8'h5A, ST_S), ent(8'h22, ST_E), ent(8'h33, ST_S));
        mem[11] = mk_row(ent(8'h44, ST_M), ent(8'h5B, ST_S), ent(8'h5A, ST_M), ent(8'h5A, ST_S));
        // set 1: invalid and duplicates
        mem[2]  = mk_row(ent(8'h00, ST_I), ent(8'h01, ST_S), ent(8'h5A, ST_I), ent(8'h10, ST_M));
        mem[3]  = mk_row(ent(8'h5A, ST_E), ent(8'h5A, ST_E), ent(8'h5A, ST_I), ent(8'h5A, ST_E));

        idle(3);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_ram_v", bus.ram_v_o, 0);
        chk("rst_ram_addr", bus.ram_addr_o, 0);
        chk("rst_sharers_v", bus.sharers_v_o, 0);
        chk("rst_hits", bus.sharers_hits_o, 0);
        chk("rst_states", bus.sharers_coh_states_o, 0);
        rst_n = 1'b1;
        idle(2);

        // Miss everywhere
        req(3, 8'h5A, 4'b0000, 4'b0000, 12'h000);
        idle(6);

        // Mixed hits, then results must hold after the pulse
        req(5, 8'h5A, 4'b1001, 4'b0001, 12'hC01);
        idle(7);
        chk("hold_hits", bus.sharers_hits_o, 4'b1001);
        chk("hold_states", bus.sharers_coh_states_o, 12'hC01);

        // Invalid and duplicates
        req(1, 8'h5A, 4'b1100, 4'b1000, 12'h480);
        idle(6);

        // Back-to-back with start held high
        k = cyc;
        bus.start_v_i = 1'b1;
        bus.set_i     = 3'd5;
        bus.tag_i     = 8'h5A;
        ad_q.push_back('{k + 1, 10});
        ad_q.push_back('{k + 2, 11});
        sb_q.push_back('{k + 4, 4'b1001, 4'b0001, 12'hC01});
        ad_q.push_back('{k + 5, 10});
        ad_q.push_back('{k + 6, 11});
        sb_q.push_back('{k + 8, 4'b0001, 4'b0000, 12'h006});
        @(negedge clk);
        bus.tag_i = 8'h11;
        @(negedge clk);
        chk("b2b_ready_busy", bus.ready_o, 0);
        idle(2);
        chk("b2b_ready_at_pulse", bus.ready_o, 1);
        @(negedge clk);
        bus.start_v_i = 1'b0;
        idle(6);

        // Reset abort in T+2
        k = cyc;
        bus.start_v_i = 1'b1;
        bus.set_i     = 3'd1;
        bus.tag_i     = 8'h5A;
        ad_q.push_back('{k + 1, 2});
        ad_q.push_back('{k + 2, 3});
        @(negedge clk);
        bus.start_v_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", bus.ready_o, 1);
        chk("abort_ram_v", bus.ram_v_o, 0);
        chk("abort_ram_addr", bus.ram_addr_o, 0);
        chk("abort_sharers_v", bus.sharers_v_o, 0);
        chk("abort_hits", bus.sharers_hits_o, 0);
        chk("abort_ways", bus.sharers_ways_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        // Normal request after the abort: every LCE hits way 0 in M
        req(3, 8'h11, 4'b1111, 4'b0000, 12'hDB6);
        idle(8);

        chk("sb_drained", sb_q.size(), 0);
        chk("ram_reads_drained", ad_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
